// File: rtl/mrc_pkg.sv
// mrc_pkg: shared FSM state encoding, state count, counter width and default timeout for mrc_scheduler
package mrc_pkg;
    localparam int unsigned NUM_STATES      = 8;
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 255;
    typedef enum logic [$clog2(NUM_STATES)-1:0] {
        IDLE, START, WAIT_X, LOAD_X, WAIT_Y, LOAD_Y, WAIT_RDY, RESP
    } state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; the requester not granted last wins a tie
// ports: valid0/valid1 requests, last_grant previous winner, enable gates the grant,
//        grant_id winning index, grant_valid a grant is issued
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    input  logic enable,
    output logic grant_id,
    output logic grant_valid
);
    assign grant_valid = enable && (valid0 || valid1);
    assign grant_id    = (valid0 && valid1) ? !last_grant : valid1;
endmodule

// File: rtl/mrc_scheduler.sv
// mrc_scheduler: arbitrates two requesters and sequences start/load pulses into the MRC datapath
// ports: reqN_* command handshake per requester, rsp_* response handshake,
//        mrc_start/mrc_load/mrc_op/mrc_data drive the datapath, mrc_x/mrc_y/mrc_ready/mrc_error/mrc_result
//        come back from it, busy is high outside IDLE
module mrc_scheduler
    import mrc_pkg::*;
#(
    parameter int unsigned      WORD_LENGTH = 16,
    parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(TIMEOUT_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic                     req0_op,
    input  logic [WORD_LENGTH-1:0]   req0_x,
    input  logic [WORD_LENGTH-1:0]   req0_y,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic                     req1_op,
    input  logic [WORD_LENGTH-1:0]   req1_x,
    input  logic [WORD_LENGTH-1:0]   req1_y,
    output logic                     req1_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic [2*WORD_LENGTH-1:0] rsp_result,
    output logic                     rsp_error,
    output logic                     rsp_timeout,
    output logic                     mrc_start,
    output logic                     mrc_load,
    output logic                     mrc_op,
    output logic [WORD_LENGTH-1:0]   mrc_data,
    input  logic                     mrc_x,
    input  logic                     mrc_y,
    input  logic                     mrc_ready,
    input  logic                     mrc_error,
    input  logic [2*WORD_LENGTH-1:0] mrc_result,
    output logic                     busy
);
    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     last_grant_q, last_grant_d;
    logic [WORD_LENGTH-1:0]   x_q, x_d, y_q, y_d, mrc_data_q, mrc_data_d;
    logic [1:0]               req_ready_q, req_ready_d;
    logic                     rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
    logic [2*WORD_LENGTH-1:0] rsp_result_q, rsp_result_d;
    logic                     rsp_error_q, rsp_error_d, rsp_timeout_q, rsp_timeout_d;
    logic                     mrc_start_q, mrc_start_d, mrc_load_q, mrc_load_d, mrc_op_q, mrc_op_d;
    logic                     grant_id, grant_valid, flag, expired;

    rr_arb2 u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (last_grant_q),
        .enable      (state_q == IDLE),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    always_comb begin
        flag          = (state_q == WAIT_X) ? mrc_x : (state_q == WAIT_Y) ? mrc_y : mrc_ready;
        expired       = cnt_q == TIMEOUT - CNT_W'(1);
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        x_d           = x_q;
        y_d           = y_q;
        req_ready_d   = 2'b00;
        rsp_id_d      = rsp_id_q;
        rsp_result_d  = rsp_result_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
        mrc_op_d      = mrc_op_q;
        case (state_q)
            IDLE: if (grant_valid) begin
                state_d      = START;
                last_grant_d = grant_id;
                rsp_id_d     = grant_id;
                req_ready_d  = grant_id ? 2'b10 : 2'b01;
                mrc_op_d     = grant_id ? req1_op : req0_op;
                x_d          = grant_id ? req1_x : req0_x;
                y_d          = grant_id ? req1_y : req0_y;
            end
            START:  state_d = WAIT_X;
            LOAD_X: state_d = mrc_op_q ? WAIT_RDY : WAIT_Y;
            LOAD_Y: state_d = WAIT_RDY;
            WAIT_X, WAIT_Y, WAIT_RDY:
                if (flag) begin
                    state_d = (state_q == WAIT_X) ? LOAD_X : (state_q == WAIT_Y) ? LOAD_Y : RESP;
                    if (state_q == WAIT_RDY) begin
                        rsp_result_d  = mrc_result;
                        rsp_error_d   = mrc_error;
                        rsp_timeout_d = 1'b0;
                    end
                end else if (expired) begin
                    state_d       = RESP;
                    rsp_result_d  = '0;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // every WAIT_* state is entered from a different state, so any change restarts the count
        cnt_d       = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
        mrc_start_d = state_d == START;
        mrc_load_d  = (state_d == LOAD_X) || (state_d == LOAD_Y);
        mrc_data_d  = (state_d == LOAD_X) ? x_q : (state_d == LOAD_Y) ? y_q : mrc_data_q;
        rsp_valid_d = state_d == RESP;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_grant_q  <= 1'b1;
            x_q           <= '0;
            y_q           <= '0;
            req_ready_q   <= 2'b00;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_result_q  <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            mrc_start_q   <= 1'b0;
            mrc_load_q    <= 1'b0;
            mrc_op_q      <= 1'b0;
            mrc_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_grant_q  <= last_grant_d;
            x_q           <= x_d;
            y_q           <= y_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_result_q  <= rsp_result_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
            mrc_start_q   <= mrc_start_d;
            mrc_load_q    <= mrc_load_d;
            mrc_op_q      <= mrc_op_d;
            mrc_data_q    <= mrc_data_d;
        end
    end

    assign req0_ready  = req_ready_q[0];
    assign req1_ready  = req_ready_q[1];
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;
    assign mrc_start   = mrc_start_q;
    assign mrc_load    = mrc_load_q;
    assign mrc_op      = mrc_op_q;
    assign mrc_data    = mrc_data_q;
    assign busy        = state_q != IDLE;
endmodule
